// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and default bus widths.
package axi4_lite_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int ID_W_DEF   = 4;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

endpackage

// File: rtl/axi4_lite_slv_regfile.sv
// Word-organised storage: byte-strobe synchronous write, combinational read,
// every word cleared by the asynchronous reset.
module axi4_lite_slv_regfile
  import axi4_lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    ridx,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees the pre-edge contents, so a same-edge read returns old data.
  assign rdata = mem_q[ridx];

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite memory slave with independent AW/W holding registers and a
// 1-cycle read path. Define AXI4_LITE_SLV_DECERR_EN for out-of-range SLVERR.
module axi4_lite_slave_mem
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [ID_W-1:0]     AWID,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  output logic [ID_W-1:0]     BID,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [ID_W-1:0]     ARID,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic [ID_W-1:0]     RID,
  output logic                RLAST
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [ID_W-1:0]   aw_id_q,   aw_id_d;
  logic              w_held_q,  w_held_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;
  logic              bvalid_q,  bvalid_d;
  resp_e             bresp_q,   bresp_d;
  logic [ID_W-1:0]   bid_q,     bid_d;
  logic              rvalid_q,  rvalid_d;
  resp_e             rresp_q,   rresp_d;
  logic [ID_W-1:0]   rid_q,     rid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_word;

  assign aw_hs  = AWVALID && !aw_held_q;
  assign w_hs   = WVALID  && !w_held_q;
  assign ar_hs  = ARVALID && !rvalid_q;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

`ifdef AXI4_LITE_SLV_DECERR_EN
  assign wr_ok = (aw_addr_q >> (IDX_W + 3)) == '0;
  assign rd_ok = (ARADDR >> (IDX_W + 3)) == '0;
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  axi4_lite_slv_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (commit && wr_ok),
    .widx  (aw_addr_q[IDX_W+2:3]),
    .wdata (w_data_q),
    .wstrb (w_strb_q),
    .ridx  (ARADDR[IDX_W+2:3]),
    .rdata (rd_word)
  );

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = AWADDR;
      aw_id_d   = AWID;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    // Commit is only possible with both holders full, so it never races a capture.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = aw_id_q;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rid_d    = ARID;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_ok ? rd_word : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign AWREADY = !aw_held_q;
  assign WREADY  = !w_held_q;
  assign ARREADY = !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = bid_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RLAST   = 1'b1;

  // Burst attributes and sub-word address bits have no effect on a single-beat slave.
  logic unused_ok;
  assign unused_ok = ^{AWLEN, AWSIZE, AWBURST, ARLEN, ARSIZE, ARBURST, WLAST,
                       AWADDR, ARADDR, aw_addr_q};

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem with a response scoreboard.
module tb_axi4_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [3:0]  AWID;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  BID;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [3:0]  ARID;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        RVALID, RREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  RID;
  logic        RLAST;

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID),
    .RLAST(RLAST)
  );

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; logic [63:0] data; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [63:0] model [16];
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
`ifdef AXI4_LITE_SLV_DECERR_EN
    return addr < 32'd128;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [63:0] data,
                                      input logic [7:0] strb);
    logic [3:0] idx;
    idx = addr[6:3];
    if (in_range(addr))
      for (int b = 0; b < 8; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
  endfunction

  function automatic void push_b(input logic [31:0] addr, input logic [3:0] id);
    b_exp_t e;
    e.id = id;
    e.resp = in_range(addr) ? 2'b00 : 2'b10;
    bq.push_back(e);
  endfunction

  function automatic void push_r(input logic [31:0] addr, input logic [3:0] id);
    r_exp_t e;
    logic [3:0] idx;
    idx = addr[6:3];
    e.id = id;
    e.resp = in_range(addr) ? 2'b00 : 2'b10;
    e.data = in_range(addr) ? model[idx] : 64'h0;
    rq.push_back(e);
  endfunction

  // Response scoreboard: a beat is consumed at the edge following a negedge with VALID&&READY.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1) begin
      if (BVALID && BREADY) begin
        chk("b_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          b_exp_t e;
          e = bq.pop_front();
          chk("bid", 64'(BID), 64'(e.id));
          chk("bresp", 64'(BRESP), 64'(e.resp));
        end
      end
      if (RVALID && RREADY) begin
        chk("r_expected", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          r_exp_t e;
          e = rq.pop_front();
          chk("rid", 64'(RID), 64'(e.id));
          chk("rresp", 64'(RRESP), 64'(e.resp));
          chk("rdata", RDATA, e.data);
          chk("rlast", 64'(RLAST), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_bvalid(input string tag);
    int n;
    n = 0;
    while (!BVALID && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(BVALID), 64'd1);
  endtask

  task automatic drive_aw_w(input logic [31:0] addr, input logic [3:0] id,
                            input logic [63:0] data, input logic [7:0] strb);
    AWVALID = 1'b1; AWADDR = addr; AWID = id;
    WVALID  = 1'b1; WDATA  = data; WSTRB = strb;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input logic [63:0] data, input logic [7:0] strb);
    drive_aw_w(addr, id, data, strb);
    push_b(addr, id);
    model_write(addr, data, strb);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_bvalid("write_bvalid");
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id);
    ARVALID = 1'b1; ARADDR = addr; ARID = id;
    push_r(addr, id);
    tick();
    ARVALID = 1'b0;
    chk("read_latency_rvalid", 64'(RVALID), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ARESETn = 1'b0;
    AWVALID = 0; AWADDR = 0; AWID = 0; AWLEN = 0; AWSIZE = 3; AWBURST = 1;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 1;
    ARVALID = 0; ARADDR = 0; ARID = 0; ARLEN = 0; ARSIZE = 3; ARBURST = 1;
    BREADY = 1; RREADY = 1;
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_wready", 64'(WREADY), 64'd1);
    chk("rst_arready", 64'(ARREADY), 64'd1);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    chk("rst_ids", {56'd0, BID, RID}, 64'd0);
    chk("rst_resps", {60'd0, BRESP, RRESP}, 64'd0);
    ARESETn = 1'b1;
    tick();

    // Same-cycle AW/W, then read back.
    drive_aw_w(32'h10, 4'd3, 64'h1122334455667788, 8'hFF);
    push_b(32'h10, 4'd3);
    model_write(32'h10, 64'h1122334455667788, 8'hFF);
    tick();
    AWVALID = 0; WVALID = 0;
    chk("t1_awready_held", 64'(AWREADY), 64'd0);
    chk("t1_bvalid_early", 64'(BVALID), 64'd0);
    tick();
    chk("t1_bvalid", 64'(BVALID), 64'd1);
    chk("t1_bid", 64'(BID), 64'd3);
    tick();
    chk("t1_bvalid_clear", 64'(BVALID), 64'd0);
    do_read(32'h10, 4'd5);
    chk("t1_rdata_direct", model[2], 64'h1122334455667788);

    // W leads AW by three cycles with partial strobes.
    WVALID = 1; WDATA = 64'hFFFFFFFFFFFFFFFF; WSTRB = 8'h0F;
    tick();
    WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wready_low", 64'(WREADY), 64'd0);
      chk("t2_no_commit", 64'(BVALID), 64'd0);
      if (i < 2) tick();
    end
    AWVALID = 1; AWADDR = 32'h18; AWID = 4'd1;
    push_b(32'h18, 4'd1);
    model_write(32'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    tick();
    AWVALID = 0;
    wait_bvalid("t2_bvalid");
    tick();
    do_read(32'h18, 4'd2);
    chk("t2_model_word", model[3], 64'h00000000FFFFFFFF);

    // Back-pressure on B while a second write queues in the holders.
    BREADY = 0;
    drive_aw_w(32'h20, 4'd7, 64'hA1A2A3A4A5A6A7A8, 8'hFF);
    push_b(32'h20, 4'd7);
    model_write(32'h20, 64'hA1A2A3A4A5A6A7A8, 8'hFF);
    tick();
    AWVALID = 0; WVALID = 0;
    wait_bvalid("t3_bvalid_first");
    drive_aw_w(32'h28, 4'd9, 64'hB1B2B3B4B5B6B7B8, 8'hFF);
    push_b(32'h28, 4'd9);
    model_write(32'h28, 64'hB1B2B3B4B5B6B7B8, 8'hFF);
    tick();
    AWVALID = 0; WVALID = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_bvalid_stable", 64'(BVALID), 64'd1);
      chk("t3_bid_stable", 64'(BID), 64'd7);
      chk("t3_awready_low", 64'(AWREADY), 64'd0);
      chk("t3_wready_low", 64'(WREADY), 64'd0);
      tick();
    end
    BREADY = 1;
    tick();
    chk("t3_bvalid_gap", 64'(BVALID), 64'd0);
    tick();
    chk("t3_bvalid_second", 64'(BVALID), 64'd1);
    chk("t3_bid_second", 64'(BID), 64'd9);
    tick();
    chk("t3_bvalid_done", 64'(BVALID), 64'd0);
    do_read(32'h28, 4'd9);

    // Commit and read to the same word on the same edge.
    do_write(32'h10, 4'd2, 64'h55, 8'hFF);
    drive_aw_w(32'h10, 4'd4, 64'hAA, 8'hFF);
    push_b(32'h10, 4'd4);
    tick();
    AWVALID = 0; WVALID = 0;
    ARVALID = 1; ARADDR = 32'h10; ARID = 4'd6;
    push_r(32'h10, 4'd6);
    model_write(32'h10, 64'hAA, 8'hFF);
    tick();
    ARVALID = 0;
    chk("t4_rvalid", 64'(RVALID), 64'd1);
    chk("t4_rdata_old", RDATA, 64'h55);
    chk("t4_bvalid", 64'(BVALID), 64'd1);
    tick();
    do_read(32'h10, 4'd6);
    chk("t4_model_new", model[2], 64'hAA);

    // Address beyond DEPTH*8.
    do_write(32'h1000, 4'd3, 64'hDEADBEEFCAFEF00D, 8'hFF);
    do_read(32'h1000, 4'd3);
    do_read(32'h0, 4'd4);

    // Reset while a read response is stalled.
    do_write(32'h08, 4'd1, 64'h0123456789ABCDEF, 8'hFF);
    RREADY = 0;
    ARVALID = 1; ARADDR = 32'h08; ARID = 4'd2;
    push_r(32'h08, 4'd2);
    tick();
    ARVALID = 0;
    chk("t6_rvalid", 64'(RVALID), 64'd1);
    tick();
    chk("t6_rdata_stable", RDATA, 64'h0123456789ABCDEF);
    #2;
    ARESETn = 0;
    #1;
    chk("t6_rvalid_async", 64'(RVALID), 64'd0);
    chk("t6_arready_async", 64'(ARREADY), 64'd1);
    chk("t6_rdata_async", RDATA, 64'd0);
    rq.delete();
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    tick();
    ARESETn = 1;
    RREADY = 1;
    tick();
    do_read(32'h08, 4'd2);
    do_read(32'h20, 4'd3);

    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
